gate_vector_sequencer: RTL and testbench

//  Sequences the built-in gate block: applies a table of 4-bit input vectors (a,b,c,d),

---
 rtl/gate_vector_sequencer_pkg.sv | 28 ++
 rtl/gate_vector_sequencer_if.sv | 29 ++
 rtl/gate_seq_hold_cnt.sv | 26 ++
 rtl/gate_vector_sequencer.sv | 109 ++++++++++
 tb/tb_gate_vector_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_vector_sequencer_pkg.sv
// Shared types and constants for the gate vector sequencer.
// Optional feature macro: GATE_SEQ_SIG_EN (capture signature).
package gate_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned SIG_W     = 16;
  localparam logic [SIG_W-1:0] SIG_TAP = 16'hB400;
  localparam int unsigned DEF_VEC_W = 4;
  localparam int unsigned DEF_OUT_W = 10;

  // Index width for n vectors, never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One signature step: LFSR shift with tap feedback, then fold in the capture
  function automatic logic [SIG_W-1:0] sig_next(input logic [SIG_W-1:0] s,
                                               input logic [SIG_W-1:0] din);
    return {s[SIG_W-2:0], ^(s & SIG_TAP)} ^ din;
  endfunction

endpackage

// File: rtl/gate_vector_sequencer_if.sv
// Config/capture bus between the test master and the gate vector sequencer.
interface gate_vector_sequencer_if
  import gate_seq_pkg::*;
#(
  parameter int unsigned NUM_VEC = 5,
  parameter int unsigned VEC_W   = DEF_VEC_W,
  parameter int unsigned OUT_W   = DEF_OUT_W
);
  localparam int unsigned IDX_W = idx_width(NUM_VEC);

  logic                     start;
  logic [NUM_VEC*VEC_W-1:0] vec_table;
  logic                     cap_valid;
  logic [OUT_W-1:0]         cap_data;
  logic [IDX_W-1:0]         cap_idx;
  logic                     busy;
  logic                     done;
  logic [SIG_W-1:0]         sig;

  modport master (
    output start, vec_table,
    input  cap_valid, cap_data, cap_idx, busy, done, sig
  );

  modport slave (
    input  start, vec_table,
    output cap_valid, cap_data, cap_idx, busy, done, sig
  );
endinterface

// File: rtl/gate_seq_hold_cnt.sv
// Hold-window counter: counts cycles a vector has been applied, flags the last one.
module gate_seq_hold_cnt #(
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc_c
);
  localparam int unsigned CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HOLD_CYC - 1);

  logic [CNT_W-1:0] hcnt;

  assign tc_c = (hcnt == TC_VAL);

  // Count while enabled, wrap to zero at terminal count
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      hcnt <= '0;
    end else if (en) begin
      hcnt <= tc_c ? '0 : hcnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/gate_vector_sequencer.sv
// Gate vector sequencer: drives a table of vectors into the gate block, holds
// each for HOLD_CYC cycles and captures the gate output once per vector.
// Optional feature macro: GATE_SEQ_SIG_EN (16-bit capture signature on bus.sig).
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned NUM_VEC  = 5,
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned VEC_W    = DEF_VEC_W,
  parameter int unsigned OUT_W    = DEF_OUT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  gate_vector_sequencer_if.slave bus,
  output logic [VEC_W-1:0]     gate_in,
  input  logic [OUT_W-1:0]     gate_out
);
  localparam int unsigned IDX_W = idx_width(NUM_VEC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             hold_tc_c;
  logic             cnt_en_c;
  logic [VEC_W-1:0] vec_next_c;

  assign cnt_en_c   = (state == ST_APPLY);
  assign vec_next_c = bus.vec_table[(32'(idx) + 32'd1) * VEC_W +: VEC_W];

  gate_seq_hold_cnt #(
    .HOLD_CYC (HOLD_CYC)
  ) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (!cnt_en_c),
    .en    (cnt_en_c),
    .tc_c  (hold_tc_c)
  );

  // Sequencer FSM with registered vector drive, capture and handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      gate_in       <= '0;
      bus.cap_valid <= 1'b0;
      bus.cap_data  <= '0;
      bus.cap_idx   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.cap_valid <= 1'b0;
      bus.done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          gate_in <= '0;
          if (bus.start) begin
            state    <= ST_APPLY;
            idx      <= '0;
            gate_in  <= bus.vec_table[VEC_W-1:0];
            bus.busy <= 1'b1;
          end
        end
        ST_APPLY: begin
          if (hold_tc_c) begin
            bus.cap_data  <= gate_out;
            bus.cap_idx   <= idx;
            bus.cap_valid <= 1'b1;
            if (idx != LAST_IDX) begin
              idx     <= idx + IDX_W'(1);
              gate_in <= vec_next_c;
            end else begin
              gate_in  <= '0;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
              state    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GATE_SEQ_SIG_EN
  logic [SIG_W-1:0] sig_q;

  // Signature: cleared on run start, folded with each captured gate output
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= '0;
    end else if (state == ST_IDLE && bus.start) begin
      sig_q <= '0;
    end else if (state == ST_APPLY && hold_tc_c) begin
      sig_q <= sig_next(sig_q, SIG_W'(gate_out));
    end
  end

  assign bus.sig = sig_q;
`else
  assign bus.sig = '0;
`endif

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Self-checking bench for gate_vector_sequencer (5 vectors x 2 cycles, plus a
// 1 vector x 1 cycle instance). Honours GATE_SEQ_SIG_EN for signature expectations.
module tb_gate_vector_sequencer;
  localparam int N = 5;
  localparam int H = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gate_vector_sequencer_if #(.NUM_VEC(N), .VEC_W(4), .OUT_W(10)) bus0 ();
  gate_vector_sequencer_if #(.NUM_VEC(1), .VEC_W(4), .OUT_W(10)) bus1 ();

  logic [3:0] gi0, gi1;
  logic [9:0] go0, go1;
  assign go0 = {6'b0, gi0};
  assign go1 = {6'b0, gi1};

  gate_vector_sequencer #(.NUM_VEC(N), .HOLD_CYC(H), .VEC_W(4), .OUT_W(10)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .gate_in(gi0), .gate_out(go0));

  gate_vector_sequencer #(.NUM_VEC(1), .HOLD_CYC(1), .VEC_W(4), .OUT_W(10)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .gate_in(gi1), .gate_out(go1));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Reference signature step, straight from the documented recurrence
  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [9:0] g);
`ifdef GATE_SEQ_SIG_EN
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {6'b0, g};
`else
    return 16'h0000;
`endif
  endfunction

  typedef struct {
    int         cyc;
    int         idx;
    logic [9:0] data;
    bit         last;
    logic [15:0] sig;
  } exp_t;

  exp_t q[$];

  // Model of the current run: vectors and the cycle window they occupy
  int         run_e = -1000;
  int         run_end = -1000;
  int         idle_from = 0;
  int         sig_clear_cyc = -1;
  logic [3:0] run_vec [N];
  logic [15:0] sig_cur = 16'h0;
  bit         checking = 1'b0;

  function automatic logic [3:0] gate_in_exp(input int c);
    if (c >= run_e && c < run_end) return run_vec[(c - run_e) / H];
    return 4'h0;
  endfunction

  // Pulse start for one cycle; the model decides whether the DUT accepts it
  task automatic pulse_start(input logic [19:0] tbl, output bit acc);
    int e;
    logic [15:0] s;
    @(posedge clk); #1;
    bus0.start = 1'b1;
    e = cyc + 1;
    acc = (e >= idle_from);
    if (acc) begin
      bus0.vec_table = tbl;
      s = 16'h0;
      for (int k = 0; k < N; k++) begin
        exp_t x;
        run_vec[k] = tbl[k*4 +: 4];
        s = sig_step(s, {6'b0, run_vec[k]});
        x.cyc  = e + (k + 1) * H;
        x.idx  = k;
        x.data = {6'b0, run_vec[k]};
        x.last = (k == N - 1);
        x.sig  = s;
        q.push_back(x);
      end
      run_e = e;
      run_end = e + N * H;
      idle_from = e + N * H + 2;
      sig_clear_cyc = e;
    end
    @(posedge clk); #1;
    bus0.start = 1'b0;
  endtask

  task automatic wait_pos(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_neg(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  // Monitor: compares every cycle of dut0 against the scoreboard and run model
  bit   mon_cv;
  bit   mon_done;
  exp_t mon_ex;
  always @(negedge clk) begin
    if (checking) begin
      if (cyc == sig_clear_cyc) sig_cur = 16'h0;
      while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
      mon_cv = (q.size() > 0) && (q[0].cyc == cyc);
      mon_done = mon_cv ? q[0].last : 1'b0;
      check("cap_valid", bus0.cap_valid, mon_cv);
      check("done", bus0.done, mon_done);
      if (mon_cv) begin
        mon_ex = q.pop_front();
        if (bus0.cap_valid) begin
          check($sformatf("cap_data[%0d]", mon_ex.idx), bus0.cap_data, mon_ex.data);
          check("cap_idx", bus0.cap_idx, mon_ex.idx);
          check($sformatf("sig_cap[%0d]", mon_ex.idx), bus0.sig, mon_ex.sig);
        end
        sig_cur = mon_ex.sig;
      end else begin
        check("sig_hold", bus0.sig, sig_cur);
      end
      check("busy", bus0.busy, (cyc >= run_e) && (cyc < run_end));
      check("gate_in", gi0, gate_in_exp(cyc));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int e;
    int busy_cnt;
    logic [3:0] v1;
    logic [31:0] r;

    bus0.start = 1'b0;
    bus0.vec_table = '0;
    bus1.start = 1'b0;
    bus1.vec_table = '0;

    // Reset, then idle
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checking = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle_gate_in", gi0, 4'h0);
      check("idle_busy", bus0.busy, 1'b0);
      check("idle_done", bus0.done, 1'b0);
      check("idle_cap_valid", bus0.cap_valid, 1'b0);
      check("idle_sig", bus0.sig, 16'h0);
    end

    // Reference table, with the documented signature checkpoints
    pulse_start(20'hF25A5, acc);
    e = run_e;
    wait_neg(e + H);
`ifdef GATE_SEQ_SIG_EN
    check("sig_after_cap0", bus0.sig, 16'h0005);
`else
    check("sig_after_cap0", bus0.sig, 16'h0000);
`endif
    wait_neg(e + 2 * H);
    check("sig_after_cap1", bus0.sig, 16'h0000);
    wait_neg(e + N * H);
    check("busy_low_after_run", bus0.busy, 1'b0);
    check("done_at_end", bus0.done, 1'b1);
    check("last_cap_idx", bus0.cap_idx, 3'd4);
    wait_pos(idle_from + 1);

    // Start pulses mid-run and in DONE are ignored; a later one starts fresh
    pulse_start(20'h12345, acc);
    e = run_e;
    pulse_start(20'h6789A, acc);
    pulse_start(20'hBCDEF, acc);
    wait_pos(e + N * H - 1);
    pulse_start(20'h0F0F0, acc);
    pulse_start(20'h3C96E, acc);
    wait_pos(idle_from + 1);

    // Reset after the second capture aborts the run
    pulse_start(20'hA5C3E, acc);
    e = run_e;
    wait_pos(e + 2 * H);
    reset = 1'b1;
    run_end = cyc + 1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    sig_cur = 16'h0;
    sig_clear_cyc = -1;
    idle_from = cyc + 1;
    @(negedge clk);
    check("rst_cap_valid", bus0.cap_valid, 1'b0);
    check("rst_done", bus0.done, 1'b0);
    check("rst_busy", bus0.busy, 1'b0);
    check("rst_gate_in", gi0, 4'h0);
    check("rst_cap_data", bus0.cap_data, 10'h0);
    check("rst_cap_idx", bus0.cap_idx, 3'd0);
    check("rst_sig", bus0.sig, 16'h0);
    repeat (12) @(posedge clk);
    #1;

    // Randomized tables, gaps and overlapping start requests
    for (int it = 0; it < 14; it++) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      r = $urandom;
      pulse_start(r[19:0], acc);
    end
    wait_pos(idle_from + 2);

    // Single vector, single-cycle hold instance
    v1 = 4'($urandom_range(1, 15));
    @(posedge clk); #1;
    bus1.vec_table = v1;
    bus1.start = 1'b1;
    e = cyc + 1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      busy_cnt += int'(bus1.busy);
      if (cyc == e) begin
        check("n1_cap_valid_e0", bus1.cap_valid, 1'b0);
        check("n1_gate_in_e0", gi1, v1);
      end
      if (cyc == e + 1) begin
        check("n1_cap_valid", bus1.cap_valid, 1'b1);
        check("n1_done", bus1.done, 1'b1);
        check("n1_cap_data", bus1.cap_data, {6'b0, v1});
        check("n1_cap_idx", bus1.cap_idx, 1'b0);
        check("n1_sig", bus1.sig, sig_step(16'h0, {6'b0, v1}));
        check("n1_gate_in_off", gi1, 4'h0);
      end
      if (cyc == e + 2) begin
        check("n1_cap_valid_after", bus1.cap_valid, 1'b0);
        check("n1_done_after", bus1.done, 1'b0);
      end
    end
    check("n1_busy_cycles", busy_cnt, 1);

    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
